// File: rtl/arrow_pkg.sv
// Shared definitions for the arrow game datapath: matcher state encoding,
// the reserved "no key" code and a sequence-length range helper.
package arrow_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int KEY_NONE = 0;

   function automatic logic len_in_range(input int len, input int max_len);
      return (len >= 1) && (len <= max_len);
   endfunction

endpackage

// File: rtl/key_press_detect.sv
// Turns a level key code into one press pulse per key-down; a key already held
// when reset is released is ignored until it has been let go.
module key_press_detect
   import arrow_pkg::*;
#(
   parameter int KEY_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [KEY_W-1:0] key_pressed,
   output logic             press,
   output logic [KEY_W-1:0] press_code
);

   logic [KEY_W-1:0] key_q;
   logic [KEY_W-1:0] key_d;
   logic             hold_q;
   logic             hold_d;
   logic             key_down;

   assign key_down = (key_pressed != KEY_W'(KEY_NONE));

   always_comb begin
      key_d  = key_pressed;
      hold_d = hold_q && key_down;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         key_q  <= '0;
         hold_q <= key_down;
      end else begin
         key_q  <= key_d;
         hold_q <= hold_d;
      end
   end

   assign press      = key_down && (key_q == KEY_W'(KEY_NONE)) && !hold_q;
   assign press_code = key_pressed;

endmodule

// File: rtl/arrow_seq_matcher.sv
// Arrow game key-sequence matcher: follows key presses against a programmable
// target sequence and reports win, miss, timeout and progress.
module arrow_seq_matcher
   import arrow_pkg::*;
#(
   parameter int KEY_W       = 4,
   parameter int MAX_LEN     = 8,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [KEY_W-1:0]             key_pressed,
   input  logic                         seq_wr_en,
   input  logic [$clog2(MAX_LEN)-1:0]   seq_wr_addr,
   input  logic [KEY_W-1:0]             seq_wr_data,
   input  logic [$clog2(MAX_LEN+1)-1:0] seq_len,
   output logic                         win,
   output logic                         miss,
   output logic                         timeout,
   output logic [$clog2(MAX_LEN+1)-1:0] progress
);

   localparam int AW = $clog2(MAX_LEN);
   localparam int PW = $clog2(MAX_LEN + 1);
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_t           state_q,    state_d;
   logic [PW-1:0]    progress_q, progress_d;
   logic             miss_q,     miss_d;
   logic             timeout_q,  timeout_d;
   logic [TW-1:0]    timer_q,    timer_d;
   logic [PW-1:0]    seq_len_q,  seq_len_d;
   logic [KEY_W-1:0] seq_mem_q [MAX_LEN];
   logic [KEY_W-1:0] seq_mem_d [MAX_LEN];

   logic             press;
   logic [KEY_W-1:0] press_code;
   logic [AW-1:0]    rd_idx;
   logic [KEY_W-1:0] exp_key;
   logic [PW-1:0]    base_prog;
   logic [PW-1:0]    next_prog;
   logic             enabled;
   logic             abort;

   key_press_detect #(
      .KEY_W(KEY_W)
   ) u_key_press_detect (
      .clk        (clk),
      .reset      (reset),
      .key_pressed(key_pressed),
      .press      (press),
      .press_code (press_code)
   );

   // A press in DONE starts a fresh attempt, so it is judged against slot 0.
   assign base_prog = (state_q == DONE) ? '0 : progress_q;
   assign next_prog = base_prog + PW'(1);
   assign rd_idx    = base_prog[AW-1:0];
   assign exp_key   = seq_mem_q[rd_idx];
   assign enabled   = len_in_range(int'(seq_len), MAX_LEN);
   assign abort     = !enabled
                    || (seq_len != seq_len_q)
                    || (seq_wr_en && (state_q != IDLE));

   always_comb begin
      seq_len_d = seq_len;
      seq_mem_d = seq_mem_q;
      if (seq_wr_en) begin
         seq_mem_d[seq_wr_addr] = seq_wr_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      progress_d = progress_q;
      miss_d     = 1'b0;
      timeout_d  = 1'b0;
      timer_d    = timer_q;

      if (abort) begin
         state_d    = IDLE;
         progress_d = '0;
         timer_d    = '0;
      end else if (press) begin
         timer_d = '0;
         if (press_code == exp_key) begin
            progress_d = next_prog;
            state_d    = (next_prog == seq_len) ? DONE : RUN;
         end else begin
            miss_d     = 1'b1;
            progress_d = '0;
            state_d    = IDLE;
         end
      end else if ((TIMEOUT_CYC != 0) && (state_q == RUN)) begin
         // A press landing on the expiry cycle was handled above, so it wins.
         if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
            timeout_d  = 1'b1;
            progress_d = '0;
            state_d    = IDLE;
            timer_d    = '0;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         progress_q <= '0;
         miss_q     <= 1'b0;
         timeout_q  <= 1'b0;
         timer_q    <= '0;
         seq_len_q  <= seq_len;
      end else begin
         state_q    <= state_d;
         progress_q <= progress_d;
         miss_q     <= miss_d;
         timeout_q  <= timeout_d;
         timer_q    <= timer_d;
         seq_len_q  <= seq_len_d;
      end
   end

   // Sequence storage survives reset so a loaded pattern need not be reloaded.
   always_ff @(posedge clk) begin
      seq_mem_q <= seq_mem_d;
   end

   assign win      = (state_q == DONE);
   assign miss     = miss_q;
   assign timeout  = timeout_q;
   assign progress = progress_q;

endmodule

// File: tb/tb_arrow_seq_matcher.sv
// Self-checking bench for arrow_seq_matcher: directed scenarios with literal
// expectations, then randomized traffic compared cycle by cycle to a reference model.
module tb_arrow_seq_matcher;

   localparam int KEY_W       = 4;
   localparam int MAX_LEN     = 8;
   localparam int TIMEOUT_CYC = 16;
   localparam int AW          = $clog2(MAX_LEN);
   localparam int PW          = $clog2(MAX_LEN + 1);

   logic             clk         = 1'b0;
   logic             reset       = 1'b1;
   logic [KEY_W-1:0] key_pressed = '0;
   logic             seq_wr_en   = 1'b0;
   logic [AW-1:0]    seq_wr_addr = '0;
   logic [KEY_W-1:0] seq_wr_data = '0;
   logic [PW-1:0]    seq_len     = '0;
   logic             win;
   logic             miss;
   logic             timeout;
   logic [PW-1:0]    progress;

   int checks = 0;
   int errors = 0;

   arrow_seq_matcher #(
      .KEY_W      (KEY_W),
      .MAX_LEN    (MAX_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_pressed(key_pressed),
      .seq_wr_en  (seq_wr_en),
      .seq_wr_addr(seq_wr_addr),
      .seq_wr_data(seq_wr_data),
      .seq_len    (seq_len),
      .win        (win),
      .miss       (miss),
      .timeout    (timeout),
      .progress   (progress)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: counts matched keys of the current attempt and cycles
   // since the last accepted press, straight from the game rules.
   int m_seq [MAX_LEN] = '{default: 0};
   int m_matched  = 0;
   bit m_win      = 1'b0;
   bit m_miss     = 1'b0;
   bit m_to       = 1'b0;
   int m_prev     = 0;
   bit m_block    = 1'b0;
   int m_idle     = 0;
   int m_len_prev = 0;
   bit m_valid    = 1'b0;

   always @(posedge clk) begin : ref_model
      int  k;
      int  len;
      bit  ev;
      bit  abort;
      int  start;
      k       = int'(key_pressed);
      len     = int'(seq_len);
      m_valid = 1'b1;
      m_miss  = 1'b0;
      m_to    = 1'b0;
      if (reset) begin
         m_matched  = 0;
         m_win      = 1'b0;
         m_prev     = 0;
         m_block    = (k != 0);
         m_idle     = 0;
         m_len_prev = len;
      end else begin
         ev = (k != 0) && (m_prev == 0) && !m_block;
         if (k == 0) m_block = 1'b0;
         m_prev = k;
         abort = (len < 1) || (len > MAX_LEN) || (len != m_len_prev)
               || (seq_wr_en && (m_matched > 0));
         m_len_prev = len;
         if (abort) begin
            m_matched = 0;
            m_win     = 1'b0;
            m_idle    = 0;
         end else if (ev) begin
            m_idle = 0;
            start  = m_win ? 0 : m_matched;
            if (k == m_seq[start]) begin
               m_matched = start + 1;
               m_win     = (m_matched == len);
            end else begin
               m_miss    = 1'b1;
               m_matched = 0;
               m_win     = 1'b0;
            end
         end else if (m_matched > 0 && !m_win) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYC) begin
               m_to      = 1'b1;
               m_matched = 0;
               m_idle    = 0;
            end
         end
      end
      if (seq_wr_en) m_seq[seq_wr_addr] = int'(seq_wr_data);
   end

   always @(negedge clk) begin
      if (m_valid) begin
         checkOutput("model_progress", int'(progress), m_matched);
         checkOutput("model_win",      int'(win),      int'(m_win));
         checkOutput("model_miss",     int'(miss),     int'(m_miss));
         checkOutput("model_timeout",  int'(timeout),  int'(m_to));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int k, input int hold);
      key_pressed = KEY_W'(k);
      repeat (hold) tick();
      key_pressed = '0;
      tick();
   endtask

   task automatic writeSlot(input int addr, input int data);
      seq_wr_en   = 1'b1;
      seq_wr_addr = AW'(addr);
      seq_wr_data = KEY_W'(data);
      tick();
      seq_wr_en   = 1'b0;
   endtask

   int lens [7] = '{0, 1, 2, 3, 4, 8, 9};

   initial begin
      reset = 1'b1;
      repeat (2) tick();
      checkOutput("reset_progress", int'(progress), 0);
      checkOutput("reset_win", int'(win), 0);
      reset = 1'b0;
      tick();
      for (int i = 0; i < MAX_LEN; i++) writeSlot(i, (i < 3) ? i + 1 : 0);
      seq_len = PW'(3);
      tick();

      // Straight match 1,2,3
      applyStimulus(1, 1);
      checkOutput("t1_progress1", int'(progress), 1);
      applyStimulus(2, 1);
      checkOutput("t1_progress2", int'(progress), 2);
      applyStimulus(3, 1);
      checkOutput("t1_progress3", int'(progress), 3);
      checkOutput("t1_win", int'(win), 1);

      // Wrong second key
      applyStimulus(1, 1);
      key_pressed = KEY_W'(1);
      tick();
      checkOutput("t2_miss", int'(miss), 1);
      checkOutput("t2_progress", int'(progress), 0);
      key_pressed = '0;
      tick();
      applyStimulus(1, 1);
      applyStimulus(2, 1);
      applyStimulus(3, 1);
      checkOutput("t2_win", int'(win), 1);

      // Timeout after 16 quiet cycles; press on the expiry cycle wins
      applyStimulus(1, 1);
      repeat (15) tick();
      checkOutput("t3_timeout", int'(timeout), 1);
      checkOutput("t3_progress0", int'(progress), 0);
      tick();
      checkOutput("t3_timeout_pulse", int'(timeout), 0);
      applyStimulus(1, 1);
      repeat (14) tick();
      key_pressed = KEY_W'(2);
      tick();
      checkOutput("t3_progress2", int'(progress), 2);
      checkOutput("t3_no_timeout", int'(timeout), 0);
      key_pressed = '0;
      tick();
      applyStimulus(3, 1);

      // Press from DONE starts a new attempt
      key_pressed = KEY_W'(1);
      tick();
      checkOutput("t4_win_drop", int'(win), 0);
      checkOutput("t4_progress1", int'(progress), 1);
      key_pressed = '0;
      tick();
      applyStimulus(2, 1);
      applyStimulus(3, 1);
      key_pressed = KEY_W'(4);
      tick();
      checkOutput("t4_win_miss", int'(win), 0);
      checkOutput("t4_miss", int'(miss), 1);
      checkOutput("t4_progress0", int'(progress), 0);
      key_pressed = '0;
      tick();

      // Held key and nonzero-to-nonzero change give a single event
      key_pressed = KEY_W'(1);
      repeat (12) tick();
      key_pressed = KEY_W'(2);
      repeat (3) tick();
      checkOutput("t5_progress", int'(progress), 1);
      key_pressed = '0;
      repeat (20) tick();

      // Disabled matcher, write during RUN, reset mid-attempt
      seq_len = '0;
      tick();
      applyStimulus(1, 1);
      applyStimulus(2, 1);
      checkOutput("t6_disabled_progress", int'(progress), 0);
      checkOutput("t6_disabled_miss", int'(miss), 0);
      seq_len = PW'(3);
      tick();
      applyStimulus(1, 1);
      checkOutput("t6_run_progress", int'(progress), 1);
      writeSlot(5, 7);
      checkOutput("t6_wr_progress", int'(progress), 0);
      checkOutput("t6_wr_miss", int'(miss), 0);
      applyStimulus(1, 1);
      key_pressed = KEY_W'(1);
      reset = 1'b1;
      tick();
      checkOutput("t6_rst_progress", int'(progress), 0);
      checkOutput("t6_rst_win", int'(win), 0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      checkOutput("t6_held_progress", int'(progress), 0);
      key_pressed = '0;
      tick();
      applyStimulus(1, 1);
      checkOutput("t6_repress_progress", int'(progress), 1);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 3) == 0)
            key_pressed = ($urandom_range(0, 1) == 1) ? '0 : KEY_W'($urandom_range(1, 4));
         seq_wr_en   = ($urandom_range(0, 59) == 0);
         seq_wr_addr = AW'($urandom_range(0, MAX_LEN - 1));
         seq_wr_data = KEY_W'($urandom_range(0, 4));
         if ($urandom_range(0, 199) == 0) seq_len = PW'(lens[$urandom_range(0, 6)]);
         reset = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset     = 1'b0;
      seq_wr_en = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
